// File: rtl/qam_word_reader.sv
// Source-side buffer for the 16-QAM transmit path: packs 32-bit host writes
// MSB-first into 128-bit words and holds them in a show-ahead FIFO for the mapper.
module qam_word_reader #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           ce,
    input  logic           flush,
    input  logic           wr_en,
    input  logic [31:0]    wr_data,
    output logic           wr_ready,
    input  logic           reader_en,
    output logic [127:0]   reader_data,
    output logic           valid_o,
    output logic [CW-1:0]  count,
    output logic [1:0]     lane,
    output logic           overflow,
    output logic           underflow
);

    localparam int PW = $clog2(DEPTH);

    // Handshakes: a host lane transfers on an edge with ce && wr_en && wr_ready;
    // a word leaves on an edge with ce && reader_en && valid_o. Requests made
    // without the matching ready/valid are dropped and raise the sticky flag.
    logic [127:0]  r_mem [DEPTH];
    logic [95:0]   r_partial;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_lane;
    logic          r_overflow;
    logic          r_underflow;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = ce && wr_en && !w_full;
    assign w_push   = w_accept && (r_lane == 2'd3);
    assign w_pop    = ce && reader_en && !w_empty;

    assign wr_ready    = !w_full;
    assign valid_o     = !w_empty;
    assign reader_data = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign lane        = r_lane;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // Memory survives flush so the head shows mem[0] afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush && w_push) begin
            r_mem[r_wr_ptr] <= {r_partial, wr_data};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_partial <= '0;
        end else if (!flush && w_accept) begin
            case (r_lane)
                2'd0:    r_partial[95:64] <= wr_data;
                2'd1:    r_partial[63:32] <= wr_data;
                2'd2:    r_partial[31:0]  <= wr_data;
                default: r_partial        <= r_partial;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lane      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lane      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lane <= r_lane + 2'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (ce && wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (ce && reader_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qam_word_reader.sv
// Directed bench for qam_word_reader: hand-computed words, immediate assertions,
// one linear stimulus sequence.
module tb_qam_word_reader;

    logic         CLK;
    logic         RST;
    logic         ce;
    logic         flush;
    logic         wr_en;
    logic [31:0]  wr_data;
    logic         wr_ready;
    logic         reader_en;
    logic [127:0] reader_data;
    logic         valid_o;
    logic [2:0]   count;
    logic [1:0]   lane;
    logic         overflow;
    logic         underflow;

    int n_pass;
    int n_total;

    qam_word_reader #(.DEPTH(4), .CW(3)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ce          (ce),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .reader_en   (reader_en),
        .reader_data (reader_data),
        .valid_o     (valid_o),
        .count       (count),
        .lane        (lane),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic lane_wr(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic push_word(input logic [127:0] w);
        lane_wr(w[127:96]);
        lane_wr(w[95:64]);
        lane_wr(w[63:32]);
        lane_wr(w[31:0]);
    endtask

    logic [127:0] fill_w [4];
    logic [127:0] wrap_w [6];
    logic [127:0] w_a, w_b, w_c, w_d;

    initial begin
        n_pass = 0;
        n_total = 0;
        fill_w[0] = 128'h10000000_10000001_10000002_10000003;
        fill_w[1] = 128'h20000000_20000001_20000002_20000003;
        fill_w[2] = 128'h30000000_30000001_30000002_30000003;
        fill_w[3] = 128'h40000000_40000001_40000002_40000003;
        wrap_w[0] = 128'hC0000000_C0000001_C0000002_C0000003;
        wrap_w[1] = 128'hC1000000_C1000001_C1000002_C1000003;
        wrap_w[2] = 128'hC2000000_C2000001_C2000002_C2000003;
        wrap_w[3] = 128'hC3000000_C3000001_C3000002_C3000003;
        wrap_w[4] = 128'hC4000000_C4000001_C4000002_C4000003;
        wrap_w[5] = 128'hC5000000_C5000001_C5000002_C5000003;
        w_a = 128'hAAAA0000_AAAA0001_AAAA0002_AAAA0003;
        w_b = 128'hBBBB0000_BBBB0001_BBBB0002_BBBB0003;
        w_c = 128'hCCCC0000_CCCC0001_CCCC0002_CCCC0003;
        w_d = 128'hDDDD0000_DDDD0001_DDDD0002_DDDD0003;

        RST = 1'b1; ce = 1'b1; flush = 1'b0; wr_en = 1'b0;
        wr_data = '0; reader_en = 1'b0;
        #23;
        chk("rst_data",     reader_data, 128'h0);
        chk("rst_valid",    128'(valid_o), 128'h0);
        chk("rst_wr_ready", 128'(wr_ready), 128'h1);
        chk("rst_count",    128'(count), 128'h0);
        chk("rst_lane",     128'(lane), 128'h0);
        chk("rst_flags",    128'({overflow, underflow}), 128'h0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Single word, lanes written back-to-back.
        wr_en = 1'b1;
        wr_data = 32'h11111111; tick();
        wr_data = 32'h22222222; tick();
        chk("sw_lane2", 128'(lane), 128'h2);
        chk("sw_valid_partial", 128'(valid_o), 128'h0);
        wr_data = 32'h33333333; tick();
        wr_data = 32'h44444444; tick();
        wr_en = 1'b0;
        chk("sw_valid", 128'(valid_o), 128'h1);
        chk("sw_count", 128'(count), 128'h1);
        chk("sw_data", reader_data, 128'h11111111_22222222_33333333_44444444);
        chk("sw_lane0", 128'(lane), 128'h0);
        reader_en = 1'b1; tick(); reader_en = 1'b0;
        chk("sw_pop_valid", 128'(valid_o), 128'h0);
        chk("sw_pop_count", 128'(count), 128'h0);
        chk("sw_pop_stale", reader_data, 128'h0);

        // Fill (words land at mem[1],mem[2],mem[3],mem[0]) and overflow.
        for (int k = 0; k < 4; k++) begin
            push_word(fill_w[k]);
        end
        chk("fill_count", 128'(count), 128'h4);
        chk("fill_wr_ready", 128'(wr_ready), 128'h0);
        chk("fill_head", reader_data, fill_w[0]);
        chk("fill_ovf_before", 128'(overflow), 128'h0);
        lane_wr(32'hDEADBEEF);
        chk("ovf_flag", 128'(overflow), 128'h1);
        chk("ovf_lane", 128'(lane), 128'h0);
        chk("ovf_count", 128'(count), 128'h4);
        reader_en = 1'b1; tick();
        chk("pop1_wr_ready", 128'(wr_ready), 128'h1);
        chk("pop1_head", reader_data, fill_w[1]);
        chk("pop1_count", 128'(count), 128'h3);
        tick();
        chk("pop2_head", reader_data, fill_w[2]);
        tick();
        chk("pop3_head", reader_data, fill_w[3]);
        chk("pop3_count", 128'(count), 128'h1);
        tick();
        chk("drain_count", 128'(count), 128'h0);
        chk("drain_valid", 128'(valid_o), 128'h0);
        chk("drain_unf_clear", 128'(underflow), 128'h0);
        tick();
        reader_en = 1'b0;
        chk("unf_flag", 128'(underflow), 128'h1);
        chk("unf_count", 128'(count), 128'h0);
        chk("unf_keeps_ovf", 128'(overflow), 128'h1);

        // Flush clears flags and pointers; head shows mem[0] = last fill word.
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fl_flags", 128'({overflow, underflow}), 128'h0);
        chk("fl_count", 128'(count), 128'h0);
        chk("fl_mem0", reader_data, fill_w[3]);

        // Wrap-around: pop each word as soon as it is visible.
        for (int j = 0; j < 6; j++) begin
            push_word(wrap_w[j]);
            chk("wrap_count1", 128'(count), 128'h1);
            chk("wrap_head", reader_data, wrap_w[j]);
            reader_en = 1'b1; tick(); reader_en = 1'b0;
            chk("wrap_count0", 128'(count), 128'h0);
        end

        // Simultaneous push and pop at count 2 (rd_ptr is 2 here).
        push_word(w_a);
        push_word(w_b);
        chk("sim_count_pre", 128'(count), 128'h2);
        chk("sim_head_pre", reader_data, w_a);
        lane_wr(w_c[127:96]);
        lane_wr(w_c[95:64]);
        lane_wr(w_c[63:32]);
        wr_en = 1'b1; wr_data = w_c[31:0]; reader_en = 1'b1;
        tick();
        wr_en = 1'b0; reader_en = 1'b0;
        chk("sim_count", 128'(count), 128'h2);
        chk("sim_head", reader_data, w_b);
        reader_en = 1'b1; tick();
        chk("sim_next", reader_data, w_c);
        tick(); reader_en = 1'b0;
        chk("sim_empty", 128'(count), 128'h0);

        // ce gating with one lane captured.
        lane_wr(32'h01234567);
        ce = 1'b0; wr_en = 1'b1; wr_data = 32'h89ABCDEF; reader_en = 1'b1;
        tick();
        wr_en = 1'b0; reader_en = 1'b0; ce = 1'b1;
        chk("ce_lane", 128'(lane), 128'h1);
        chk("ce_count", 128'(count), 128'h0);
        chk("ce_flags", 128'({overflow, underflow}), 128'h0);

        // Flush mid-word, with a write on the same edge.
        lane_wr(32'h76543210);
        chk("mw_lane2", 128'(lane), 128'h2);
        flush = 1'b1; wr_en = 1'b1; wr_data = 32'hFFFFFFFF;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("mw_fl_lane", 128'(lane), 128'h0);
        chk("mw_fl_flags", 128'({overflow, underflow}), 128'h0);
        push_word(w_d);
        chk("mw_word_valid", 128'(valid_o), 128'h1);
        chk("mw_word", reader_data, w_d);

        // Asynchronous reset after 3 lanes, checked before the next edge.
        lane_wr(32'h1);
        lane_wr(32'h2);
        lane_wr(32'h3);
        RST = 1'b1;
        #2;
        chk("ar_lane", 128'(lane), 128'h0);
        chk("ar_count", 128'(count), 128'h0);
        chk("ar_valid", 128'(valid_o), 128'h0);
        chk("ar_data", reader_data, 128'h0);
        chk("ar_wr_ready", 128'(wr_ready), 128'h1);
        tick();
        RST = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
